// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory request arbiter: FSM states, request kinds,
// width codes and arbitration defaults.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic [1:0] KIND_IF = 2'b00;
  localparam logic [1:0] KIND_LD = 2'b01;
  localparam logic [1:0] KIND_ST = 2'b10;

  localparam logic [2:0] LDW_BU = 3'b000;
  localparam logic [2:0] LDW_HU = 3'b001;
  localparam logic [2:0] LDW_W  = 3'b010;
  localparam logic [2:0] LDW_B  = 3'b100;
  localparam logic [2:0] LDW_H  = 3'b101;

  localparam logic [2:0] STW_B = 3'b000;
  localparam logic [2:0] STW_H = 3'b001;
  localparam logic [2:0] STW_W = 3'b010;

  localparam logic [1:0] IO_REGION_DEF    = 2'b11;
  localparam int         STARVE_LIMIT_DEF = 8;

  // Bit positions inside the one-hot grant vector.
  localparam int G_IF = 0;
  localparam int G_LD = 1;
  localparam int G_ST = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational arbitration: eligibility, store > load > ifetch priority and
// the ifetch starvation override. Grants only when en is high.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int         SW           = 4,
  parameter logic [1:0] IO_REGION    = IO_REGION_DEF
) (
  input  logic          en,
  input  logic          rollback,
  input  logic          io_buffer_full,
  input  logic          if_req,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic [1:0]    st_region,
  input  logic [SW-1:0] starve_cnt,
  output logic [2:0]    grant,
  output logic          starve_inc,
  output logic          starve_clr
);

  logic st_el;
  logic ld_el;
  logic if_el;
  logic starve_hit;

  always_comb begin
    st_el      = st_req && !((st_region == IO_REGION) && io_buffer_full);
    ld_el      = ld_req && !rollback;
    if_el      = if_req && !rollback;
    starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
    grant      = '0;
    if (en) begin
      if (if_el && starve_hit) grant[G_IF] = 1'b1;
      else if (st_el)          grant[G_ST] = 1'b1;
      else if (ld_el)          grant[G_LD] = 1'b1;
      else if (if_el)          grant[G_IF] = 1'b1;
    end
    // A loss only happens when someone else was granted, so en is implied.
    starve_inc = en && if_el && !grant[G_IF];
    starve_clr = !if_req || grant[G_IF];
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-channel memory request arbiter for ifetch, load and store drain.
// Optional MEM_ARB_PERF_EN adds wrapping completion/abort counters.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic [1:0] IO_REGION    = IO_REGION_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  input  logic         io_buffer_full,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic         if_done,
  output logic [511:0] if_line,
  input  logic         ld_req,
  input  logic [31:0]  ld_addr,
  input  logic [2:0]   ld_width,
  output logic         ld_done,
  output logic [31:0]  ld_data,
  input  logic         st_req,
  input  logic [31:0]  st_addr,
  input  logic [31:0]  st_data,
  input  logic [2:0]   st_width,
  output logic         st_done,
  output logic         m_valid,
  output logic [1:0]   m_kind,
  output logic [31:0]  m_addr,
  output logic [31:0]  m_wdata,
  output logic [2:0]   m_width,
  output logic         m_abort,
  input  logic         m_done,
  input  logic [31:0]  m_rdata,
  input  logic [511:0] m_line,
  output logic [1:0]   dbg_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_if_cnt,
  output logic [31:0]  perf_ld_cnt,
  output logic [31:0]  perf_st_cnt,
  output logic [31:0]  perf_abort_cnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          done_pend;
  logic [2:0]    grant;
  logic          starve_inc;
  logic          starve_clr;
  logic          abort_now;
  logic          fin_now;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW),
    .IO_REGION    (IO_REGION)
  ) u_pick (
    .en             (state == IDLE),
    .rollback       (rollback),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .ld_req         (ld_req),
    .st_req         (st_req),
    .st_region      (st_addr[17:16]),
    .starve_cnt     (starve_cnt),
    .grant          (grant),
    .starve_inc     (starve_inc),
    .starve_clr     (starve_clr)
  );

  // Handshake: m_valid is a level held with stable m_* fields from grant until
  // the cycle after m_done (or rollback abort); m_done is a single-cycle pulse.
  assign abort_now = (state == BUSY) && rollback && (m_kind != KIND_ST);
  assign fin_now   = (state == BUSY) && !abort_now && (m_done || done_pend);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      done_pend  <= 1'b0;
      m_valid    <= 1'b0;
      m_kind     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_width    <= '0;
      m_abort    <= 1'b0;
      if_done    <= 1'b0;
      ld_done    <= 1'b0;
      st_done    <= 1'b0;
      if_line    <= '0;
      ld_data    <= '0;
    end else begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      m_abort <= 1'b0;
      // A completion during a stall is parked until rdy returns.
      if ((state == BUSY) && !rdy && m_done && !done_pend) begin
        done_pend <= 1'b1;
        if (m_kind == KIND_LD) ld_data <= m_rdata;
        if (m_kind == KIND_IF) if_line <= m_line;
      end
      if (rdy) begin
        if (starve_clr) starve_cnt <= '0;
        else if (starve_inc && (starve_cnt != SW'(STARVE_LIMIT)))
          starve_cnt <= starve_cnt + SW'(1);
        case (state)
          IDLE: begin
            if (|grant) begin
              m_valid <= 1'b1;
              state   <= BUSY;
              if (grant[G_ST]) begin
                m_kind  <= KIND_ST;
                m_addr  <= st_addr;
                m_wdata <= st_data;
                m_width <= st_width;
              end else if (grant[G_LD]) begin
                m_kind  <= KIND_LD;
                m_addr  <= ld_addr;
                m_wdata <= '0;
                m_width <= ld_width;
              end else begin
                m_kind  <= KIND_IF;
                m_addr  <= if_addr;
                m_wdata <= '0;
                m_width <= 3'b000;
              end
            end
          end
          BUSY: begin
            if (abort_now) begin
              m_valid   <= 1'b0;
              m_abort   <= 1'b1;
              done_pend <= 1'b0;
              state     <= DRAIN;
            end else if (fin_now) begin
              m_valid   <= 1'b0;
              done_pend <= 1'b0;
              state     <= IDLE;
              case (m_kind)
                KIND_IF: begin
                  if_done <= 1'b1;
                  if (!done_pend) if_line <= m_line;
                end
                KIND_LD: begin
                  ld_done <= 1'b1;
                  if (!done_pend) ld_data <= m_rdata;
                end
                default: st_done <= 1'b1;
              endcase
            end
          end
          DRAIN:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_cnt    <= '0;
      perf_ld_cnt    <= '0;
      perf_st_cnt    <= '0;
      perf_abort_cnt <= '0;
    end else if (rdy) begin
      if (fin_now && (m_kind == KIND_IF)) perf_if_cnt <= perf_if_cnt + 32'd1;
      if (fin_now && (m_kind == KIND_LD)) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (fin_now && (m_kind == KIND_ST)) perf_st_cnt <= perf_st_cnt + 32'd1;
      if (abort_now) perf_abort_cnt <= perf_abort_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench for mem_req_arbiter; checks perf counters too
// when built with MEM_ARB_PERF_EN.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int EW = 72;
  localparam logic [2:0] T_REQ = 3'd0;
  localparam logic [2:0] T_IF  = 3'd1;
  localparam logic [2:0] T_LD  = 3'd2;
  localparam logic [2:0] T_ST  = 3'd3;
  localparam logic [2:0] T_AB  = 3'd4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         rollback = 1'b0;
  logic         io_buffer_full = 1'b0;
  logic         if_req = 1'b0;
  logic [31:0]  if_addr = '0;
  logic         if_done;
  logic [511:0] if_line;
  logic         ld_req = 1'b0;
  logic [31:0]  ld_addr = '0;
  logic [2:0]   ld_width = '0;
  logic         ld_done;
  logic [31:0]  ld_data;
  logic         st_req = 1'b0;
  logic [31:0]  st_addr = '0;
  logic [31:0]  st_data = '0;
  logic [2:0]   st_width = '0;
  logic         st_done;
  logic         m_valid;
  logic [1:0]   m_kind;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [2:0]   m_width;
  logic         m_abort;
  logic         m_done = 1'b0;
  logic [31:0]  m_rdata = '0;
  logic [511:0] m_line = '0;
  logic [1:0]   dbg_state;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]  perf_if_cnt, perf_ld_cnt, perf_st_cnt, perf_abort_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_mv = 1'b0;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_line(if_line),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_width(ld_width),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_width(st_width), .st_done(st_done),
    .m_valid(m_valid), .m_kind(m_kind), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_width(m_width), .m_abort(m_abort), .m_done(m_done),
    .m_rdata(m_rdata), .m_line(m_line), .dbg_state(dbg_state)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_cnt(perf_if_cnt), .perf_ld_cnt(perf_ld_cnt),
    .perf_st_cnt(perf_st_cnt), .perf_abort_cnt(perf_abort_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input logic [2:0] tag, input logic [1:0] kind,
                                       input logic [31:0] addr, input logic [31:0] data,
                                       input logic [2:0] width);
    return {tag, kind, addr, data, width};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard
  task automatic sb_check(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected got=%h exp=none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL sb_event got=%h exp=%h", got, e);
      end
      if (got[71:69] == T_IF) begin
        total++;
        if (if_line !== {16{e[34:3]}}) begin
          bad++;
          $display("FAIL sb_if_line got=%h exp=%h", if_line[63:0], {2{e[34:3]}});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_mv = 1'b0;
    end else begin
      if (m_valid && !prev_mv) sb_check(ev(T_REQ, m_kind, m_addr, m_wdata, m_width));
      if (if_done) sb_check(ev(T_IF, 2'd0, 32'd0, if_line[31:0], 3'd0));
      if (ld_done) sb_check(ev(T_LD, 2'd0, 32'd0, ld_data, 3'd0));
      if (st_done) sb_check(ev(T_ST, 2'd0, 32'd0, 32'd0, 3'd0));
      if (m_abort) sb_check(ev(T_AB, 2'd0, 32'd0, 32'd0, 3'd0));
      prev_mv = m_valid;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [1:0] kind, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] width);
    exp_q.push_back(ev(T_REQ, kind, addr, data, width));
  endtask

  task automatic push_done(input logic [2:0] tag, input logic [31:0] data);
    exp_q.push_back(ev(tag, 2'd0, 32'd0, data, 3'd0));
  endtask

  // Memory controller: waits for a request, then completes it after dly cycles.
  task automatic respond(input logic [31:0] rd, input int dly);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    if (!m_valid) begin
      total++;
      bad++;
      $display("FAIL m_valid_timeout got=0 exp=1");
    end
    repeat (dly) tick();
    m_done = 1'b1;
    m_rdata = rd;
    m_line = {16{rd}};
    tick();
    m_done = 1'b0;
    m_rdata = '0;
    m_line = '0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // Reset state
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_kind_addr", {30'd0, m_kind, m_addr}, 64'd0);
    check("rst_dones", 64'({if_done, ld_done, st_done, m_abort}), 64'd0);
    check("rst_data", {31'd0, |if_line, ld_data}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Store beats load in the same cycle; load follows in the next IDLE cycle
    push_req(KIND_ST, 32'h100, 32'h1234_5678, STW_W);
    push_done(T_ST, 32'd0);
    push_req(KIND_LD, 32'h200, 32'd0, LDW_W);
    push_done(T_LD, 32'hDEAD_BEEF);
    st_req = 1'b1; st_addr = 32'h100; st_data = 32'h1234_5678; st_width = STW_W;
    ld_req = 1'b1; ld_addr = 32'h200; ld_width = LDW_W;
    tick();
    check("st_first_kind", {61'd0, m_valid, m_kind}, {61'd0, 1'b1, KIND_ST});
    respond(32'd0, 1);
    check("st_done_pulse", 64'(st_done), 64'd1);
    st_req = 1'b0;
    tick();
    check("ld_next_kind", {61'd0, m_valid, m_kind}, {61'd0, 1'b1, KIND_LD});
    respond(32'hDEAD_BEEF, 2);
    check("ld_done_pulse", {31'd0, ld_done, ld_data}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    ld_req = 1'b0;
    tick();
    check("ld_done_one_cycle", 64'(ld_done), 64'd0);

    // Rollback during a load, with a colliding m_done that must be dropped
    push_req(KIND_LD, 32'h300, 32'd0, LDW_B);
    exp_q.push_back(ev(T_AB, 2'd0, 32'd0, 32'd0, 3'd0));
    ld_req = 1'b1; ld_addr = 32'h300; ld_width = LDW_B;
    tick();
    tick();
    rollback = 1'b1; m_done = 1'b1; m_rdata = 32'h55;
    tick();
    check("rb_abort", {62'd0, m_abort, m_valid}, {62'd0, 1'b1, 1'b0});
    check("rb_drain", 64'(dbg_state), 64'(DRAIN));
    rollback = 1'b0; m_done = 1'b0; m_rdata = '0; ld_req = 1'b0;
    tick();
    check("rb_idle", {61'd0, m_abort, dbg_state}, {61'd0, 1'b0, IDLE});
    tick();
    check("rb_no_ld_done", 64'(ld_done), 64'd0);

    // IO store blocked by a full buffer does not block ifetch
    push_req(KIND_IF, 32'h1000, 32'd0, 3'd0);
    push_done(T_IF, 32'hCAFE_F00D);
    push_req(KIND_ST, 32'h3_0000, 32'hA5A5_A5A5, STW_B);
    push_done(T_ST, 32'd0);
    io_buffer_full = 1'b1;
    st_req = 1'b1; st_addr = 32'h3_0000; st_data = 32'hA5A5_A5A5; st_width = STW_B;
    if_req = 1'b1; if_addr = 32'h1000;
    tick();
    check("io_if_first", 64'(m_kind), 64'(KIND_IF));
    respond(32'hCAFE_F00D, 1);
    check("if_done_pulse", {31'd0, if_done, if_line[511:480]}, {31'd0, 1'b1, 32'hCAFE_F00D});
    if_req = 1'b0;
    tick();
    tick();
    check("io_store_held", 64'(m_valid), 64'd0);
    io_buffer_full = 1'b0;
    tick();
    check("io_store_go", {61'd0, m_valid, m_kind}, {61'd0, 1'b1, KIND_ST});
    respond(32'd0, 0);
    st_req = 1'b0;
    tick();

    // Starvation: ifetch forced through on the 9th decision of a store stream
    for (int i = 0; i < 8; i++) begin
      push_req(KIND_ST, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), STW_W);
      push_done(T_ST, 32'd0);
    end
    push_req(KIND_IF, 32'h2040, 32'd0, 3'd0);
    push_done(T_IF, 32'h0BAD_F00D);
    push_req(KIND_ST, 32'h420, 32'h1008, STW_W);
    push_done(T_ST, 32'd0);
    if_req = 1'b1; if_addr = 32'h2040;
    st_req = 1'b1; st_addr = 32'h400; st_data = 32'h1000; st_width = STW_W;
    for (int i = 0; i < 8; i++) begin
      respond(32'd0, 1);
      st_addr = 32'h400 + 32'(4 * (i + 1));
      st_data = 32'h1000 + 32'(i + 1);
    end
    tick();
    check("starve_if_forced", 64'(m_kind), 64'(KIND_IF));
    respond(32'h0BAD_F00D, 1);
    if_req = 1'b0;
    respond(32'd0, 1);
    st_req = 1'b0;
    tick();

    // Completion during a stall is held until rdy returns
    push_req(KIND_LD, 32'h500, 32'd0, LDW_H);
    push_done(T_LD, 32'h0000_BEEF);
    ld_req = 1'b1; ld_addr = 32'h500; ld_width = LDW_H;
    tick();
    rdy = 1'b0; m_done = 1'b1; m_rdata = 32'h0000_BEEF;
    tick();
    m_done = 1'b0; m_rdata = '0;
    check("stall_no_done", {62'd0, ld_done, m_valid}, {62'd0, 1'b0, 1'b1});
    tick();
    check("stall_still_held", 64'(ld_done), 64'd0);
    rdy = 1'b1;
    tick();
    check("stall_release", {31'd0, ld_done, ld_data}, {31'd0, 1'b1, 32'h0000_BEEF});
    ld_req = 1'b0;
    tick();

`ifdef MEM_ARB_PERF_EN
    check("perf_if_ld", {perf_if_cnt, perf_ld_cnt}, {32'd2, 32'd2});
    check("perf_st_ab", {perf_st_cnt, perf_abort_cnt}, {32'd11, 32'd1});
`endif

    // Reset in the middle of an ifetch
    push_req(KIND_IF, 32'h3000, 32'd0, 3'd0);
    if_req = 1'b1; if_addr = 32'h3000;
    tick();
    tick();
    rst = 1'b1; m_done = 1'b1; m_line = {16{32'h7777_7777}};
    tick();
    check("rst_mid_outputs", {59'd0, m_valid, if_done, m_abort, dbg_state}, 64'd0);
    check("rst_mid_line", {31'd0, |if_line, m_addr}, 64'd0);
`ifdef MEM_ARB_PERF_EN
    check("rst_perf", 64'(perf_if_cnt | perf_ld_cnt | perf_st_cnt | perf_abort_cnt), 64'd0);
`endif
    rst = 1'b0; if_req = 1'b0; m_done = 1'b0; m_line = '0;
    repeat (4) tick();

    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates the single memory-controller request channel between three requesters: instruction-line refill (ifetch), LSB load, and committed-store drain.
- Sequences one transaction at a time. Cancels speculative transactions (ifetch, load) on rollback; committed stores always complete.
- Sits between ifetch/LSB and the byte-serial memory controller.

Parameters:
- STARVE_LIMIT, 8: number of consecutive lost arbitration decisions after which a pending ifetch is force-granted.
- IO_REGION, 2'b11: value of addr[17:16] that marks memory-mapped IO.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low = stall
- rollback  in  1  ROB flush
- io_buffer_full  in  1  IO output buffer full
- if_req  in  1  line refill request; held until if_done
- if_addr  in  32  refill address; aligned to a 64-byte line
- if_done  out  1  one-cycle pulse: line valid on if_line
- if_line  out  512  returned line, registered
- ld_req  in  1  load request; held until ld_done
- ld_addr  in  32  load address
- ld_width  in  3  000 lb-unsigned, 001 lh-unsigned, 010 lw, 100 lb, 101 lh
- ld_done  out  1  one-cycle pulse
- ld_data  out  32  load result, registered
- st_req  in  1  committed store request; held until st_done
- st_addr  in  32  store address
- st_data  in  32  store data
- st_width  in  3  000 sb, 001 sh, 010 sw
- st_done  out  1  one-cycle pulse
- m_valid  out  1  request to memory controller; level signal
- m_kind  out  2  00 ifetch, 01 load, 10 store
- m_addr  out  32  request address
- m_wdata  out  32  store data
- m_width  out  3  width code
- m_abort  out  1  one-cycle cancel of the in-flight request
- m_done  in  1  one-cycle completion from memory controller
- m_rdata  in  32  load data, valid with m_done
- m_line  in  512  line data, valid with m_done

Behaviour:
- Reset values: all outputs 0, state IDLE, starve counter 0, grant register 0.
- States: IDLE, BUSY, DRAIN.
- Arbitration happens in IDLE only, when rdy=1.
- Eligibility:
  - st: st_req && !(st_addr[17:16]==IO_REGION && io_buffer_full).
  - ld: ld_req && !rollback.
  - if: if_req && !rollback.
- Priority: st > ld > if, except that if starve_cnt==STARVE_LIMIT and if is eligible, if wins.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each IDLE decision in which if is eligible but loses.
  - Clears when if is granted or when if_req=0.
- Grant: on a win, register kind, addr, data and width; assert m_valid next cycle (latency 1 from request to m_valid); enter BUSY.
- BUSY:
  - m_valid and all m_* fields held stable.
  - On m_done: deassert m_valid next cycle; pulse the matching x_done next cycle with ld_data/if_line registered from m_rdata/m_line; return to IDLE.
  - The next grant can occur in the IDLE cycle that follows.
  - Minimum spacing between requests is one idle cycle.
- Rollback in BUSY with kind ifetch or load:
  - Deassert m_valid and pulse m_abort next cycle; enter DRAIN.
  - No done is issued to the requester.
  - An m_done in the same cycle as the rollback is discarded.
- Rollback with kind store: ignored; the store completes normally.
- DRAIN:
  - Lasts exactly one cycle; any m_done seen is discarded; then IDLE.
  - The memory controller guarantees no m_done for an aborted request after the m_abort cycle.
- rdy=0:
  - No new grant; state and m_* fields held.
  - An m_done arriving is still captured, and its done pulse is emitted on the first rdy=1 cycle.
- Simultaneous ld_req and st_req: the store is granted. A store to IO while io_buffer_full stays pending and does not block ld or if.
- rst mid-transaction: immediate return to IDLE; m_valid drops; no done pulse emitted.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_if_cnt, perf_ld_cnt, perf_st_cnt and perf_abort_cnt, each 32-bit and wrapping.
  - Each counter increments on the corresponding done pulse or m_abort pulse.
  - All counters clear on rst and hold when rdy=0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: IDLE, BUSY, DRAIN.
  - m_kind codes.
  - Load/store width codes.
  - IO_REGION default.
- Sub-module mem_arb_pick: combinational eligibility, priority and starvation override. Returns a one-hot grant plus the starve increment/clear signal.

Test Plan:
- st_req=1 and ld_req=1 in the same IDLE cycle (st_addr=0x100) -> m_kind=10 next cycle; after m_done, st_done pulses; ld is granted in the following IDLE cycle.
- ld lw at 0x200, m_done with m_rdata=0xDEADBEEF -> ld_data=0xDEADBEEF and ld_done pulses exactly one cycle after m_done.
- ld in BUSY, rollback raised -> m_abort pulses once, no ld_done, DRAIN lasts 1 cycle; an m_done injected in the rollback cycle is ignored.
- st to 0x30000 with io_buffer_full=1 plus if_req at 0x1000 -> if is granted first; the store is granted after io_buffer_full=0.
- if_req held while a stream of stores keeps st_req=1 -> if is force-granted on decision STARVE_LIMIT+1 (the 9th with default 8); starve counter then 0.
- rst asserted during BUSY ifetch -> all outputs 0 next cycle, no if_done; with MEM_ARB_PERF_EN, all perf counters are 0.
